// File: rtl/mem_burst_slave.sv
// Burst memory slave: single-port RAM with wait-state insertion, address wrap and request rejection.
// Latency: read data valid WAIT_STATES+2 cycles after the request; later beats every WAIT_STATES+1 cycles.
// Backpressure: freeze stalls everything, including pending pulses; write beats wait in WDATA for wr_valid.
module mem_burst_slave #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int MEM_DEPTH     = 4096,
   parameter int WAIT_STATES   = 1,
   parameter int BURST_WIDTH   = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     rd_req,
   input  logic                     wr_req,
   input  logic [ADDRESS_WIDTH-1:0] addr_in,
   input  logic [BURST_WIDTH-1:0]   burst_len,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     wr_valid,
   input  logic                     freeze,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     module_dv,
   output logic                     err,
   output logic                     busy,
   output logic                     last
);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int WC_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [ADDRESS_WIDTH:0]   DEPTH_V  = (ADDRESS_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = ADDRESS_WIDTH'(MEM_DEPTH - 1);
   localparam logic [WC_W-1:0]          WC_END   = WC_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, WDATA} state_t;

   state_t                   state, state_n, first_st;
   logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [BURST_WIDTH:0]     beats;
   logic [WC_W-1:0]          wait_cnt;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic                     is_wr, dv_q, last_q, err_q;
   logic                     accept, bad_addr, start, do_access, final_beat;

   always_comb begin
      first_st   = (WAIT_STATES == 0) ? ACCESS : WAIT;
      accept     = (state == IDLE) && !freeze && (rd_req || wr_req);
      bad_addr   = {1'b0, addr_in} >= DEPTH_V;
      start      = accept && !bad_addr;
      do_access  = (state == ACCESS) && !freeze;
      final_beat = (beats == (BURST_WIDTH+1)'(1));
      state_n    = state;
      if (!freeze) begin
         case (state)
            IDLE:    if (start) state_n = first_st;
            WAIT:    if (wait_cnt == WC_END) state_n = ACCESS;
            ACCESS:  if (final_beat) state_n = IDLE;
                     else if (is_wr) state_n = WDATA;
                     else state_n = first_st;
            WDATA:   if (wr_valid) state_n = first_st;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q   <= '0;
         beats    <= '0;
         wait_cnt <= '0;
         wdata_q  <= '0;
         is_wr    <= 1'b0;
         rd_data  <= '0;
         dv_q     <= 1'b0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (!freeze) begin
         // Pulses are held (and masked at the output) while frozen, so they appear late rather than lost.
         dv_q     <= do_access || (accept && bad_addr);
         last_q   <= do_access && final_beat;
         err_q    <= accept && bad_addr;
         wait_cnt <= (state == WAIT && state_n == WAIT) ? wait_cnt + WC_W'(1) : '0;
         if (accept && bad_addr) rd_data <= '0;
         if (start) begin
            addr_q  <= addr_in;
            beats   <= {1'b0, burst_len} + (BURST_WIDTH+1)'(1);
            is_wr   <= wr_req;
            wdata_q <= wr_data;
         end
         if (do_access) begin
            if (!is_wr) rd_data <= mem[addr_q[IDX_W-1:0]];
            addr_q <= (addr_q == ADDR_MAX) ? '0 : addr_q + ADDRESS_WIDTH'(1);
            beats  <= beats - (BURST_WIDTH+1)'(1);
         end
         if (state == WDATA && wr_valid) wdata_q <= wr_data;
      end
   end

   // No reset on the array: contents survive rstn.
   always_ff @(posedge clk) begin
      if (do_access && is_wr) mem[addr_q[IDX_W-1:0]] <= wdata_q;
   end

   assign busy      = (state != IDLE);
   assign module_dv = dv_q & ~freeze;
   assign err       = err_q & ~freeze;
   assign last      = last_q & ~freeze;
endmodule
